axis_frame_sequencer: RTL and testbench

Sequencer that sits between the AXI-Stream test-pattern generator and the downstream consumer. It chops the generator's continuous beat stream into frames of programmable length with `tlast`, idle gaps between frames, and a programmable frame count (or free-run). It drives the generator's `enable` input and reports busy/done status to the control plane.

---
 rtl/axis_frame_sequencer_if.sv | 23 ++
 rtl/axis_frame_sequencer.sv | 127 ++++++++++++
 tb/tb_axis_frame_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/axis_frame_sequencer_if.sv
// Stream bundle between generator, frame sequencer and downstream consumer.
// master = sequencer view, slave = generator/consumer (environment) view.
interface axis_frame_sequencer_if #(
  parameter int TDATA_WIDTH = 32
) ();
  logic [TDATA_WIDTH-1:0] s_axis_tdata;
  logic                   s_axis_tvalid;
  logic                   s_axis_tready;
  logic [TDATA_WIDTH-1:0] m_axis_tdata;
  logic                   m_axis_tvalid;
  logic                   m_axis_tready;
  logic                   m_axis_tlast;

  modport master (
    input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
    output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );

  modport slave (
    output s_axis_tdata, s_axis_tvalid, m_axis_tready,
    input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast
  );
endinterface

// File: rtl/axis_frame_sequencer.sv
// Chops a continuous AXI-Stream beat stream into tlast-terminated frames with idle gaps.
// Optional macro AXIS_FRAME_SEQ_FLUSH_EN: discard generator beats outside STREAM.
module axis_frame_sequencer #(
  parameter int TDATA_WIDTH = 32,
  parameter int LEN_WIDTH   = 16
) (
  input  logic                 m_axis_aclk,
  input  logic                 m_axis_aresetn,
  input  logic                 start,
  input  logic                 stop,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic [LEN_WIDTH-1:0] gap_len,
  input  logic [LEN_WIDTH-1:0] frame_count,
  output logic                 gen_enable,
  output logic                 busy,
  output logic                 done,
  output logic [LEN_WIDTH-1:0] frames_sent,
  axis_frame_sequencer_if.master axis
);

  typedef enum logic [1:0] {ST_IDLE, ST_STREAM, ST_GAP, ST_DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);

  state_t                 r_state, w_next;
  logic [LEN_WIDTH-1:0]   r_frame_len, r_gap_len, r_frame_count;
  logic [LEN_WIDTH-1:0]   r_beat_cnt, r_gap_cnt, r_frames_sent;
  logic                   r_stop_pend;

  logic                   w_stream, w_beat, w_at_last, w_last_beat, w_stop_any;
  logic                   w_count_hit, w_gap_end;
  logic [LEN_WIDTH-1:0]   w_sent_inc, w_len;
  logic [TDATA_WIDTH-1:0] w_tdata;

  assign w_len       = (frame_len == '0) ? ONE : frame_len;
  assign w_stream    = (r_state == ST_STREAM);
  assign w_beat      = w_stream & axis.s_axis_tvalid & axis.m_axis_tready;
  assign w_at_last   = (r_beat_cnt == r_frame_len - ONE);
  assign w_last_beat = w_beat & w_at_last;
  // a stop arriving on the last beat itself still ends the run without a gap
  assign w_stop_any  = r_stop_pend | stop;
  assign w_sent_inc  = r_frames_sent + ONE;
  assign w_count_hit = (r_frame_count != '0) && (w_sent_inc == r_frame_count);
  assign w_gap_end   = (r_gap_cnt == r_gap_len - ONE);

  assign w_tdata            = axis.s_axis_tdata;
  assign axis.m_axis_tdata  = w_tdata;
  assign axis.m_axis_tvalid = w_stream & axis.s_axis_tvalid;
  assign axis.m_axis_tlast  = w_stream & w_at_last;
`ifdef AXIS_FRAME_SEQ_FLUSH_EN
  assign axis.s_axis_tready = ~w_stream | axis.m_axis_tready;
`else
  assign axis.s_axis_tready = w_stream & axis.m_axis_tready;
`endif
  assign frames_sent = r_frames_sent;

  always_comb begin
    w_next     = r_state;
    gen_enable = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) w_next = ST_STREAM;
      end
      ST_STREAM: begin
        gen_enable = 1'b1;
        if (w_last_beat) begin
          if (w_stop_any || w_count_hit) w_next = ST_DONE;
          else if (r_gap_len != '0)      w_next = ST_GAP;
        end
      end
      ST_GAP: begin
        gen_enable = 1'b1;
        if (w_stop_any)     w_next = ST_DONE;
        else if (w_gap_end) w_next = ST_STREAM;
      end
      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge m_axis_aclk or negedge m_axis_aresetn) begin
    if (!m_axis_aresetn) begin
      r_state       <= ST_IDLE;
      r_frame_len   <= ONE;
      r_gap_len     <= '0;
      r_frame_count <= '0;
      r_beat_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_frames_sent <= '0;
      r_stop_pend   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          r_stop_pend <= 1'b0;
          if (start) begin
            r_frame_len   <= w_len;
            r_gap_len     <= gap_len;
            r_frame_count <= frame_count;
            r_beat_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_frames_sent <= '0;
          end
        end
        ST_STREAM: begin
          if (stop) r_stop_pend <= 1'b1;
          r_gap_cnt <= '0;
          if (w_beat) r_beat_cnt <= w_at_last ? '0 : r_beat_cnt + ONE;
          if (w_last_beat) r_frames_sent <= w_sent_inc;
        end
        ST_GAP: begin
          if (stop) r_stop_pend <= 1'b1;
          r_gap_cnt <= r_gap_cnt + ONE;
        end
        ST_DONE: r_stop_pend <= 1'b0;
        default: r_stop_pend <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_frame_sequencer.sv
// Directed bench for axis_frame_sequencer: scoreboard queue of expected beats,
// monitor pops on each accepted output beat.
module tb_axis_frame_sequencer;
  localparam int TW = 32;
  localparam int LW = 16;
`ifdef AXIS_FRAME_SEQ_FLUSH_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, stop = 1'b0;
  logic [LW-1:0] frame_len = '0, gap_len = '0, frame_count = '0;
  logic          gen_enable, busy, done;
  logic [LW-1:0] frames_sent;
  logic [TW-1:0] gen_data = '0;
  logic          gen_fire = 1'b0;

  axis_frame_sequencer_if #(.TDATA_WIDTH(TW)) axis ();

  axis_frame_sequencer #(.TDATA_WIDTH(TW), .LEN_WIDTH(LW)) dut (
    .m_axis_aclk(clk), .m_axis_aresetn(rst_n),
    .start(start), .stop(stop),
    .frame_len(frame_len), .gap_len(gap_len), .frame_count(frame_count),
    .gen_enable(gen_enable), .busy(busy), .done(done), .frames_sent(frames_sent),
    .axis(axis)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int cyc = 0, start_cyc = 0, last_tlast_cyc = -100;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [TW-1:0] d; logic l; } exp_t;
  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // incrementing-count generator: advances only on an accepted beat
  assign axis.s_axis_tdata = gen_data;
  initial forever begin
    @(negedge clk);
    gen_fire = axis.s_axis_tvalid && axis.s_axis_tready;
    @(posedge clk);
    #2;
    if (gen_fire) gen_data = gen_data + 1;
  end

  // monitor: compares every presented beat against queue head, pops on acceptance
  always @(negedge clk) begin
    if (rst_n && axis.m_axis_tvalid) begin
      if (sb.size() == 0) begin
        n_chk++; n_err++;
        $display("FAIL beat_unexpected: got data %0h last %0b, expected no beat", axis.m_axis_tdata, axis.m_axis_tlast);
      end else begin
        chk("beat_data", axis.m_axis_tdata, sb[0].d);
        chk("beat_last", axis.m_axis_tlast, sb[0].l);
        if (axis.m_axis_tready) begin
          if (axis.m_axis_tlast) last_tlast_cyc = cyc;
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic push_frames(input logic [TW-1:0] base, input int len, input int nfr, input int gap);
    exp_t e;
    for (int f = 0; f < nfr; f++)
      for (int b = 0; b < len; b++) begin
        e.d = base + TW'(f * (len + FL * gap) + b);
        e.l = (b == len - 1);
        sb.push_back(e);
      end
  endtask

  // leaves caller in the first STREAM cycle (start cycle + 1)
  task automatic run(input int len, input int gap, input int cnt, input logic [TW-1:0] base);
    @(posedge clk); #1;
    axis.s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    gen_data = base;
    frame_len = LW'(len); gap_len = LW'(gap); frame_count = LW'(cnt);
    start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    axis.s_axis_tvalid = 1'b1;
  endtask

  task automatic wait_done(input string nm, input int exp_lat, input int exp_frames);
    bit seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_chk++; n_err++;
      $display("FAIL %s_done_timeout: got no done pulse, expected one", nm);
    end else begin
      chk({nm, "_done_cycle"}, cyc - start_cyc, exp_lat);
      chk({nm, "_done_after_tlast"}, cyc - last_tlast_cyc, 1);
      chk({nm, "_frames_sent"}, frames_sent, exp_frames);
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, done, 0);
      chk({nm, "_busy_idle"}, busy, 0);
      chk({nm, "_sb_empty"}, sb.size(), 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    axis.s_axis_tvalid = 1'b1;
    axis.m_axis_tready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gen_enable", gen_enable, 0);
    chk("rst_tvalid", axis.m_axis_tvalid, 0);
    chk("rst_tlast", axis.m_axis_tlast, 0);
    chk("rst_s_tready", axis.s_axis_tready, FL);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_frames_sent", frames_sent, 0);
    rst_n = 1'b1;

    // 3 frames of 4, gap 2: done 17 cycles after start
    run(4, 2, 3, 32'd100);
    push_frames(32'd100, 4, 3, 2);
    wait_done("t1", 17, 3);

    // frame_len 0 behaves as 1
    run(0, 0, 2, 32'd200);
    push_frames(32'd200, 1, 2, 0);
    wait_done("t2", 3, 2);

    // free-run, stop on beat 2 of frame 3
    run(5, 0, 0, 32'd300);
    push_frames(32'd300, 5, 3, 0);
    chk("t3_gen_enable", gen_enable, 1);
    chk("t3_busy", busy, 1);
    repeat (11) begin @(posedge clk); #1; end
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    wait_done("t3", 16, 3);

    // downstream ready toggling: accepted beats at start+2/4/6
    run(3, 0, 1, 32'd400);
    push_frames(32'd400, 3, 1, 0);
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          axis.m_axis_tready = i[0];
          #1;
          if (i < 6) chk("t4_tready_pass", axis.s_axis_tready, axis.m_axis_tready);
          @(posedge clk); #1;
        end
        axis.m_axis_tready = 1'b1;
      end
      wait_done("t4", 7, 1);
    join

    // start during STREAM with a new length is ignored
    run(4, 0, 1, 32'd500);
    push_frames(32'd500, 4, 1, 0);
    @(posedge clk); #1;
    frame_len = 16'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", 5, 1);

    // reset mid-frame: outputs drop immediately, no tlast on partial frame
    run(8, 0, 1, 32'd600);
    push_frames(32'd600, 3, 1, 0);
    sb[2].l = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("t6_rst_tvalid", axis.m_axis_tvalid, 0);
    chk("t6_rst_tlast", axis.m_axis_tlast, 0);
    chk("t6_rst_gen_enable", gen_enable, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_frames_sent", frames_sent, 0);
    chk("t6_rst_s_tready", axis.s_axis_tready, FL);
    chk("t6_partial_beats", sb.size(), 0);
    axis.s_axis_tvalid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // generator valid held through GAP
    run(2, 3, 2, 32'd700);
    push_frames(32'd700, 2, 2, 3);
    repeat (2) begin @(posedge clk); #1; end
    chk("t7_gap_s_tready", axis.s_axis_tready, FL);
    chk("t7_gap_tvalid", axis.m_axis_tvalid, 0);
    chk("t7_gap_gen_enable", gen_enable, 1);
    wait_done("t7", 8, 2);

    chk("final_sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
